instr_fetch_unit: RTL

Instruction fetch front end that supplies 32-bit instruction words to the multicycle control unit. It holds the PC and issues word-aligned read requests to instruction memory over a valid/ready request channel with a fixed-order response channel. It registers returned words into an IR slot presented to the control unit with a valid/take handshake. It also accepts branch redirects from the datapath, flushing stale and in-flight words.

---
 rtl/instr_fetch_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch front end for the multicycle control unit: holds the PC, issues one
// word-aligned read at a time to instruction memory, and presents returned
// words on an IR slot with a valid/take handshake. Branch redirects flush
// held and in-flight words.
// Build option: define INSTR_FETCH_PREFETCH_EN for a 2-entry prefetch queue;
// leave it undefined for a single IR slot (queue logic compiled out).
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_take,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

`ifdef INSTR_FETCH_PREFETCH_EN
    localparam logic [1:0] CAPACITY = 2'd2;
`else
    localparam logic [1:0] CAPACITY = 2'd1;
`endif
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
`ifdef INSTR_FETCH_PREFETCH_EN
    logic [31:0]         tail_q, tail_d;
    logic [ADDR_W-1:0]   tail_pc_q, tail_pc_d;
    logic                tail_valid_q, tail_valid_d;
`endif

    logic                pop;
    logic                push;
    logic [1:0]          occupied;
    logic                slot_free;

    // Queue update: pop on take, push on a live response, flush on redirect.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        pop        = ir_take && ir_valid_q;
        push       = (state_q == S_WAIT) && mem_rsp_valid && !redirect;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
`ifdef INSTR_FETCH_PREFETCH_EN
        tail_d       = tail_q;
        tail_pc_d    = tail_pc_q;
        tail_valid_d = tail_valid_q;
        if (pop) begin
            ir_d         = tail_q;
            ir_pc_d      = tail_pc_q;
            ir_valid_d   = tail_valid_q;
            tail_valid_d = 1'b0;
        end
        // Push lands in the head if the pop (or nothing) left it empty.
        if (push) begin
            if (ir_valid_d) begin
                tail_d       = mem_rsp_data;
                tail_pc_d    = inflight_pc_q;
                tail_valid_d = 1'b1;
            end else begin
                ir_d       = mem_rsp_data;
                ir_pc_d    = inflight_pc_q;
                ir_valid_d = 1'b1;
            end
        end
        if (redirect) begin
            ir_valid_d   = 1'b0;
            tail_valid_d = 1'b0;
        end
        occupied = {1'b0, ir_valid_d} + {1'b0, tail_valid_d};
`else
        if (pop) begin
            ir_valid_d = 1'b0;
        end
        if (push) begin
            ir_d       = mem_rsp_data;
            ir_pc_d    = inflight_pc_q;
            ir_valid_d = 1'b1;
        end
        if (redirect) begin
            ir_valid_d = 1'b0;
        end
        occupied = {1'b0, ir_valid_d};
`endif
        // Post-update occupancy, so a take this cycle frees a slot for next cycle's request.
        slot_free = occupied < CAPACITY;
    end

    // Fetch FSM: one request outstanding; redirect overrides the PC in every state.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        case (state_q)
            S_IDLE: begin
                if (!redirect && slot_free) state_d = S_REQ;
            end
            S_REQ: begin
                // Without acceptance a redirect simply retargets the pending request.
                if (mem_req_ready) begin
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + WORD_BYTES;
                    state_d       = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving with the redirect is the one being discarded,
                // so there is nothing left to drain.
                if (redirect) state_d = mem_rsp_valid ? S_REQ : S_DRAIN;
                else if (mem_rsp_valid) state_d = slot_free ? S_REQ : S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rsp_valid) state_d = S_REQ;
            end
        endcase
        if (redirect) fetch_pc_d = redirect_pc & ALIGN_MASK;
    end

    // Control and head-slot registers, synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            ir_q          <= '0;
            ir_pc_q       <= RESET_PC;
            ir_valid_q    <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
            tail_valid_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
`ifdef INSTR_FETCH_PREFETCH_EN
            tail_valid_q  <= tail_valid_d;
`endif
        end
    end

`ifdef INSTR_FETCH_PREFETCH_EN
    // Tail payload storage, qualified by tail_valid_q.
    always_ff @(posedge clock) begin
        // NOTE: payload is deliberately not reset; the valid bit alone marks it meaningful.
        tail_q    <= tail_d;
        tail_pc_q <= tail_pc_d;
    end
`endif

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = fetch_pc_q;
    assign ir            = ir_q;
    assign ir_valid      = ir_valid_q;
    assign ir_pc         = ir_pc_q;

endmodule
